stream_demux: RTL and testbench

Registered 1-to-N stream demultiplexer: accepts one WIDTH-bit word per cycle on a valid/ready input and delivers it to the output lane chosen by `in_sel`, through a one-entry holding slot per lane. It is the distributing counterpart to the team's 2:1 select logic. It sits wherever one producer feeds several independently back-pressured consumers. Out-of-range selects are consumed, dropped and counted so the producer never stalls on a bad address.

---
 rtl/stream_demux_pkg.sv | 10 +
 rtl/stream_demux_slot.sv | 38 +++
 rtl/stream_demux.sv | 57 +++++
 tb/tb_stream_demux.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/stream_demux_pkg.sv
// Shared types and helpers for the 1-to-N stream demultiplexer.
package stream_demux_pkg;
  localparam int DEMUX_MAX_OUT = 16;

  typedef enum logic {SLOT_EMPTY = 1'b0, SLOT_FULL = 1'b1} slot_state_t;

  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/stream_demux_slot.sv
// One-entry holding slot per output lane: load, drain and same-cycle pass-through.
module demux_slot
  import stream_demux_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             drain,
  output logic             valid,
  output logic [WIDTH-1:0] data
);
  slot_state_t state;

  // Load only arrives when the slot is empty or draining, so load always wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SLOT_EMPTY;
      data  <= '0;
    end else begin
      case (state)
        SLOT_EMPTY: if (load) begin
          state <= SLOT_FULL;
          data  <= load_data;
        end
        SLOT_FULL: begin
          if (load)       data  <= load_data;
          else if (drain) state <= SLOT_EMPTY;
        end
        default: state <= SLOT_EMPTY;
      endcase
    end
  end

  assign valid = (state == SLOT_FULL);
endmodule

// File: rtl/stream_demux.sv
// Registered 1-to-N stream demux; out-of-range selects are swallowed and counted.
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int N_OUT = 2,
  parameter int SEL_W = sel_width(N_OUT),
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WIDTH-1:0]       in_data,
  input  logic [SEL_W-1:0]       in_sel,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [N_OUT*WIDTH-1:0] out_data,
  output logic [N_OUT-1:0]       out_valid,
  input  logic [N_OUT-1:0]       out_ready,
  output logic [CNT_W-1:0]       drop_cnt
);
  logic [N_OUT-1:0]            lane_hit;
  logic [N_OUT-1:0]            lane_rdy;
  logic [N_OUT-1:0]            lane_load;
  logic [N_OUT-1:0][WIDTH-1:0] lane_data;
  logic                        sel_legal;
  logic                        accept;

  genvar k;
  generate
    for (k = 0; k < N_OUT; k++) begin : g_lane
      assign lane_hit[k]  = (in_sel == SEL_W'(k));
      assign lane_rdy[k]  = !out_valid[k] || out_ready[k];
      assign lane_load[k] = accept && lane_hit[k];

      demux_slot #(.WIDTH(WIDTH)) u_slot (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (lane_load[k]),
        .load_data (in_data),
        .drain     (out_ready[k]),
        .valid     (out_valid[k]),
        .data      (lane_data[k])
      );
    end
  endgenerate

  // out_ready feeds in_ready combinationally so a full lane can pass through.
  assign sel_legal = |lane_hit;
  assign in_ready  = !(|(lane_hit & ~lane_rdy));
  assign accept    = in_valid && in_ready;
  assign out_data  = lane_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                       drop_cnt <= '0;
    else if (accept && !sel_legal && drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
  end
endmodule

// File: tb/tb_stream_demux.sv
// Randomized + directed bench for stream_demux against a per-lane pending-word model.
module tb_stream_demux;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // DUT A: 2 lanes, 4-bit words
  logic [3:0] a_in_data = '0;
  logic       a_in_sel = '0;
  logic       a_in_valid = 1'b0;
  logic       a_in_ready;
  logic [7:0] a_out_data;
  logic [1:0] a_out_valid;
  logic [1:0] a_out_ready = '0;
  logic [7:0] a_drop_cnt;

  // DUT B: 3 lanes so that select 3 is out of range
  logic [3:0]  b_in_data = '0;
  logic [1:0]  b_in_sel = '0;
  logic        b_in_valid = 1'b0;
  logic        b_in_ready;
  logic [11:0] b_out_data;
  logic [2:0]  b_out_valid;
  logic [2:0]  b_out_ready = '0;
  logic [7:0]  b_drop_cnt;

  stream_demux #(.WIDTH(4), .N_OUT(2), .CNT_W(8)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .in_data(a_in_data), .in_sel(a_in_sel),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .out_data(a_out_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .drop_cnt(a_drop_cnt));

  stream_demux #(.WIDTH(4), .N_OUT(3), .CNT_W(8)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(b_in_data), .in_sel(b_in_sel),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .out_data(b_out_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .drop_cnt(b_drop_cnt));

  int checks = 0;
  int errors = 0;

  // Model for DUT A: words accepted but not yet consumed, per lane (at most one).
  logic [3:0] pend [2][$];
  logic [3:0] last_word [2];
  int         delivered [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      pend[k].delete();
      last_word[k] = '0;
    end
  endtask

  // One cycle on DUT A; returns at posedge+1.
  task automatic step_a(input logic vld, input logic sel, input logic [3:0] d, input logic [1:0] ordy);
    logic       exp_rdy;
    logic [1:0] take;
    logic [1:0] exp_vld;
    a_in_valid = vld; a_in_sel = sel; a_in_data = d; a_out_ready = ordy;
    #1;
    exp_rdy = (pend[sel].size() == 0) || ordy[sel];
    chk("a_in_ready", 32'(a_in_ready), 32'(exp_rdy));
    for (int k = 0; k < 2; k++) begin
      take[k] = (pend[k].size() > 0) && ordy[k];
      chk("a_consume", 32'(a_out_valid[k] && a_out_ready[k]), 32'(take[k]));
      if (take[k]) chk("a_deliver_data", 32'(a_out_data[k*4 +: 4]), 32'(pend[k][0]));
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++)
      if (take[k]) begin
        void'(pend[k].pop_front());
        delivered[k]++;
      end
    if (vld && exp_rdy) begin
      pend[sel].push_back(d);
      last_word[sel] = d;
    end
    #1;
    for (int k = 0; k < 2; k++) exp_vld[k] = pend[k].size() > 0;
    chk("a_out_valid", 32'(a_out_valid), 32'(exp_vld));
    chk("a_out_data", 32'(a_out_data), 32'({last_word[1], last_word[0]}));
    chk("a_drop_cnt", 32'(a_drop_cnt), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (checks=%0d)", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    delivered[0] = 0; delivered[1] = 0;
    #2;
    chk("rst_in_ready", 32'(a_in_ready), 32'd1);
    chk("rst_b_in_ready", 32'(b_in_ready), 32'd1);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("rst_out_valid", 32'(a_out_valid), 32'd0);
    chk("rst_out_data", 32'(a_out_data), 32'h00);
    chk("rst_drop_cnt", 32'(a_drop_cnt), 32'd0);
    chk("rst_idle_ready", 32'(a_in_ready), 32'd1);

    // Basic routing
    step_a(1'b1, 1'b0, 4'hA, 2'b11);
    chk("route_lane0", 32'(a_out_data[3:0]), 32'hA);
    step_a(1'b1, 1'b1, 4'h5, 2'b11);
    chk("route_lane1", 32'(a_out_data[7:4]), 32'h5);
    step_a(1'b0, 1'b0, 4'h0, 2'b11);

    // Back-pressure on lane 0, lane 1 unaffected, then pass-through
    step_a(1'b1, 1'b0, 4'h3, 2'b10);
    a_in_valid = 1'b1; a_in_sel = 1'b0; a_in_data = 4'h7; a_out_ready = 2'b10;
    #1 chk("bp_stall", 32'(a_in_ready), 32'd0);
    step_a(1'b1, 1'b0, 4'h7, 2'b10);
    step_a(1'b1, 1'b1, 4'h9, 2'b10);
    chk("bp_lane1", 32'(a_out_data[7:4]), 32'h9);
    step_a(1'b1, 1'b0, 4'h7, 2'b11);
    chk("bp_pass_through", 32'(a_out_data[3:0]), 32'h7);
    step_a(1'b0, 1'b0, 4'h0, 2'b11);

    // Full-rate stream to lane 1
    delivered[1] = 0;
    for (int i = 0; i < 64; i++) step_a(1'b1, 1'b1, 4'($urandom), 2'b11);
    step_a(1'b0, 1'b0, 4'h0, 2'b11);
    chk("stream64_delivered", 32'(delivered[1]), 32'd64);

    // Random mixed traffic
    for (int i = 0; i < 300; i++)
      step_a(1'($urandom), 1'($urandom), 4'($urandom), 2'($urandom));
    step_a(1'b0, 1'b0, 4'h0, 2'b11);
    step_a(1'b0, 1'b0, 4'h0, 2'b11);

    // Illegal select on the 3-lane instance
    b_in_valid = 1'b1; b_in_sel = 2'd3; b_out_ready = 3'b000;
    for (int i = 0; i < 300; i++) begin
      b_in_data = 4'($urandom);
      #1 chk("ill_in_ready", 32'(b_in_ready), 32'd1);
      @(posedge clk); #1;
      chk("ill_out_valid", 32'(b_out_valid), 32'd0);
      chk("ill_drop_cnt", 32'(b_drop_cnt), 32'((i + 1 > 255) ? 255 : i + 1));
    end
    b_in_sel = 2'd2; b_in_data = 4'h6;
    #1 chk("b_legal_ready", 32'(b_in_ready), 32'd1);
    @(posedge clk); #1;
    chk("b_lane2_valid", 32'(b_out_valid), 32'b100);
    chk("b_lane2_data", 32'(b_out_data), 32'h600);
    chk("b_lane2_stall", 32'(b_in_ready), 32'd0);
    b_in_valid = 1'b0;
    @(posedge clk); #1;
    chk("b_drop_hold", 32'(b_drop_cnt), 32'd255);

    // Async reset with both lanes full
    step_a(1'b1, 1'b0, 4'hC, 2'b00);
    step_a(1'b1, 1'b1, 4'hD, 2'b00);
    chk("pre_rst_full", 32'(a_out_valid), 32'b11);
    a_in_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("async_out_valid", 32'(a_out_valid), 32'd0);
    chk("async_out_data", 32'(a_out_data), 32'd0);
    chk("async_b_drop", 32'(b_drop_cnt), 32'd0);
    chk("async_in_ready", 32'(a_in_ready), 32'd1);
    model_reset();
    #2 rst_n = 1'b1;
    for (int i = 0; i < 20; i++)
      step_a(1'($urandom), 1'($urandom), 4'($urandom), 2'($urandom));
    step_a(1'b1, 1'b1, 4'hE, 2'b11);
    step_a(1'b0, 1'b0, 4'h0, 2'b11);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
